// File: rtl/led_driver_pkg.sv
// Shared types and defaults for the board LED driver.
package led_driver_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_PWM_BITS = 8;

  typedef logic [DEF_WIDTH-1:0] led_vec_t;

  localparam led_vec_t LED_ALL_ON  = '1;
  localparam led_vec_t LED_ALL_OFF = '0;

endpackage : led_driver_pkg

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter and brightness compare for LED dimming.
module led_pwm_gen
  import led_driver_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pwm_cnt_nxt;

  // Counter wraps naturally from all-ones back to zero.
  always_comb begin
    pwm_cnt_nxt = pwm_cnt + PWM_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt_nxt;
    end
  end

  // Full-scale brightness bypasses the compare so there is no off slot.
  always_comb begin
    pwm_on = (brightness == {PWM_BITS{1'b1}}) | (pwm_cnt < brightness);
  end

endmodule : led_pwm_gen

// File: rtl/led_driver.sv
// 8-LED bank driver: combinational master enable gated by mask, PWM dimming and blink.
module led_driver
  import led_driver_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned PWM_BITS  = DEF_PWM_BITS,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a,
  input  logic [WIDTH-1:0]    led_mask,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                blink_en,
  output logic [WIDTH-1:0]    q
);

  localparam int unsigned BLINK_CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_CNT_W-1:0] BLINK_TERM = BLINK_CNT_W'(BLINK_DIV - 1);

  logic                   pwm_on;
  logic [BLINK_CNT_W-1:0] blink_cnt;
  logic [BLINK_CNT_W-1:0] blink_cnt_nxt;
  logic                   blink_ph;
  logic                   blink_ph_nxt;
  logic                   blink_on;
  logic                   lit;

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .brightness (brightness),
    .pwm_on     (pwm_on)
  );

  // Blink prescaler: idle at count 0 / on-phase while disabled.
  always_comb begin
    blink_cnt_nxt = '0;
    blink_ph_nxt  = 1'b1;
    if (blink_en) begin
      blink_ph_nxt = blink_ph;
      if (blink_cnt == BLINK_TERM) begin
        blink_cnt_nxt = '0;
        blink_ph_nxt  = ~blink_ph;
      end else begin
        blink_cnt_nxt = blink_cnt + BLINK_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_ph  <= blink_ph_nxt;
    end
  end

  // Output gate is combinational so a and rst_n reach the pins with no clock latency.
  always_comb begin
    blink_on = blink_ph;
    lit      = a & pwm_on & blink_on & rst_n;
    q        = {WIDTH{lit}} & led_mask;
  end

endmodule : led_driver

// File: tb/tb_led_driver.sv
// Directed bench for led_driver with a queue-based scoreboard of expected values.
module tb_led_driver;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned PWM_BITS  = 8;
  localparam int unsigned BLINK_DIV = 4;

  logic                clk;
  logic                rst_n;
  logic                a;
  logic [WIDTH-1:0]    led_mask;
  logic [PWM_BITS-1:0] brightness;
  logic                blink_en;
  logic [WIDTH-1:0]    q;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] sb[$];

  led_driver #(
    .WIDTH     (WIDTH),
    .PWM_BITS  (PWM_BITS),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .led_mask   (led_mask),
    .brightness (brightness),
    .blink_en   (blink_en),
    .q          (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input logic [31:0] exp);
    sb.push_back(exp);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%0h but scoreboard empty", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  initial begin
    int unsigned on_cnt;
    int unsigned off_cnt;
    logic [7:0]  exp_q;

    rst_n = 1'b0; a = 1'b1; led_mask = 8'hFF; brightness = 8'hFF; blink_en = 1'b0;
    #1;
    expect_val(32'h00); check("reset_q", 32'(q));
    #20;
    @(negedge clk); rst_n = 1'b1;

    // T1: a drives q with clock-free timing
    a = 1'b0; #10;
    expect_val(32'h00); check("t1_a0", 32'(q));
    a = 1'b1; #10;
    expect_val(32'hFF); check("t1_a1", 32'(q));

    // T2: asynchronous reset gate
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    expect_val(32'h00); check("t2_rst_low", 32'(q));
    rst_n = 1'b1; #1;
    expect_val(32'hFF); check("t2_rst_high", 32'(q));

    // T3: mask
    led_mask = 8'hA5; #1;
    expect_val(32'hA5); check("t3_mask_a5", 32'(q));
    a = 1'b0; #1;
    expect_val(32'h00); check("t3_mask_a0", 32'(q));
    led_mask = 8'h3C; a = 1'b1; #1;
    expect_val(32'h3C); check("t3_mask_3c", 32'(q));
    led_mask = 8'hFF;

    // T4: PWM duty over one full counter period
    @(negedge clk); brightness = 8'h40;
    on_cnt = 0; off_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); #1;
      if (q === 8'hFF) on_cnt++;
      else if (q === 8'h00) off_cnt++;
    end
    expect_val(32'd64);  check("t4_on_cycles_40", on_cnt);
    expect_val(32'd192); check("t4_off_cycles_40", off_cnt);

    brightness = 8'h00; on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); #1;
      if (q !== 8'h00) on_cnt++;
    end
    expect_val(32'd0); check("t4_bright0_lit", on_cnt);

    brightness = 8'h01; on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); #1;
      if (q === 8'hFF) on_cnt++;
    end
    expect_val(32'd1); check("t4_bright1_on", on_cnt);

    brightness = 8'hFF; off_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); #1;
      if (q !== 8'hFF) off_cnt++;
    end
    expect_val(32'd0); check("t4_brightff_gaps", off_cnt);

    // T5: blink with BLINK_DIV=4; sample k is taken after k rising edges
    @(negedge clk);
    blink_en = 1'b1; #1;
    expect_val(32'hFF); check("t5_blink_k0", 32'(q));
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk); #1;
      exp_q = (((k / 4) % 2) == 0) ? 8'hFF : 8'h00;
      expect_val(32'(exp_q));
      check($sformatf("t5_blink_k%0d", k), 32'(q));
    end
    blink_en = 1'b0; #1;
    expect_val(32'h00); check("t5_disable_before_clk", 32'(q));
    @(negedge clk); #1;
    expect_val(32'hFF); check("t5_disable_after_clk", 32'(q));
    repeat (6) @(negedge clk);
    #1;
    expect_val(32'hFF); check("t5_steady_on", 32'(q));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_led_driver
